// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   8N1 UART transmitter fed by a small circular byte FIFO. Upstream pushes
//   bytes with a VALID/READY handshake; the FSM pops them and serialises
//   each one as start bit, 8 data bits LSB-first, stop bit. Queued bytes go
//   out back-to-back with no idle gap between frames.
//
// Parameters
//   BIT_RATE    line bit rate in bits/s
//   CLK_HZ      clk_i frequency in Hz (CLK_HZ/BIT_RATE must be >= 2)
//   FIFO_DEPTH  FIFO entries, power of two, >= 2
//
// Ports
//   clk_i    system clock, all state updates on the rising edge
//   rst_i    asynchronous active-high reset; flushes FIFO, abandons frame
//   data_i   byte to transmit
//   valid_i  data_i valid; accepted on an edge where valid_i && ready_o
//   ready_o  FIFO not full; decoded from registers only
//   tx_o     serial line, idle high, driven from a flop
//   busy_o   high while a frame is on the line
//   count_o  bytes waiting in the FIFO (excludes the byte being shifted)
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int BIT_RATE   = 9600,
  parameter int CLK_HZ     = 12_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int CLK_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CW          = $clog2(CLK_PER_BIT) + 1;
  localparam int AW          = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] BIT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW:0]   FILL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FILL_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   FILL_FULL = (AW+1)'(FIFO_DEPTH);

  if (CLK_PER_BIT < 2) begin : g_bad_rate
    $error("uart_tx_fifo: CLK_HZ/BIT_RATE must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic [7:0]     shift_q, shift_d;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [7:0]     mem_q [FIFO_DEPTH];

  logic           ready_s;
  logic           push_s;
  logic           pop_s;
  logic           bit_end_s;
  logic           fifo_empty_s;
  logic [7:0]     head_s;

  assign ready_s      = (count_q != FILL_FULL);
  assign push_s       = valid_i && ready_s;
  assign fifo_empty_s = (count_q == FILL_ZERO);
  assign bit_end_s    = (bit_cnt_q == BIT_LAST);
  assign head_s       = mem_q[rd_ptr_q];

  assign ready_o = ready_s;
  assign tx_o    = tx_q;
  assign busy_o  = busy_q;
  assign count_o = count_q;

  // Frame sequencer: next state, bit timing, shift register and next TX level.
  // tx_d is the level the line takes from the coming edge, so the line flop
  // already shows the start bit on the edge that pops the byte.
  always_comb begin
    state_d   = state_q;
    tx_d      = 1'b1;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    pop_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s     = 1'b1;
          shift_d   = head_s;
          bit_cnt_d = CNT_ZERO;
          state_d   = ST_START;
          tx_d      = 1'b0;
        end else begin
          bit_cnt_d = CNT_ZERO;
          tx_d      = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          bit_cnt_d = CNT_ZERO;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
          tx_d      = 1'b0;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          bit_cnt_d = CNT_ZERO;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = ST_STOP;
            tx_d      = 1'b1;
          end else begin
            // Next data bit is the one about to land in shift_q[0].
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
          tx_d      = shift_q[0];
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          bit_cnt_d = CNT_ZERO;
          if (!fifo_empty_s) begin
            // Chain straight into the next frame without an idle bit.
            pop_s   = 1'b1;
            shift_d = head_s;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
          tx_d      = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = CNT_ZERO;
        bit_idx_d = 3'd0;
        tx_d      = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // FIFO bookkeeping: pointer advance and occupancy for push, pop or both.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + FILL_ONE;
      2'b01:   count_d = count_q - FILL_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control and line registers; reset abandons any frame in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      shift_q   <= 8'h00;
      bit_cnt_q <= CNT_ZERO;
      bit_idx_q <= 3'd0;
      wr_ptr_q  <= PTR_ZERO;
      rd_ptr_q  <= PTR_ZERO;
      count_q   <= FILL_ZERO;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage; cleared on reset so no stale byte can ever be observed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
8N1 UART transmitter with a small byte FIFO. It is the transmit counterpart to the team's uart_rx receiver and uses the same BIT_RATE/CLK_HZ parameterisation.
- Upstream logic pushes bytes with a VALID/READY handshake.
- The block serialises each byte onto TX as start bit, 8 data bits LSB-first, then stop bit.
- Queued bytes are sent back-to-back with no idle gap.
- Sits between the design's byte producers and the board's UART TX pin.

Parameters:
BIT_RATE, 9600, line bit rate in bits/s
CLK_HZ, 12_000_000, CLK frequency in Hz
FIFO_DEPTH, 4, FIFO entries; power of two, ≥2
(derived) CLK_PER_BIT = CLK_HZ/BIT_RATE (integer division); must be ≥2, elaboration error otherwise

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  asynchronous, active-high reset
DATA  input  8  byte to transmit
VALID  input  1  DATA valid; byte accepted on a CLK edge where VALID && READY
READY  output  1  FIFO not full (COUNT != FIFO_DEPTH); combinational from registers only, never from VALID
TX  output  1  serial line; idle high; registered
BUSY  output  1  high while a frame is on the line (state != IDLE)
COUNT  output  $clog2(FIFO_DEPTH)+1  bytes waiting in FIFO, excluding the byte being shifted out

Behaviour:
- Reset (async assert, any time including mid-frame):
  - TX=1, BUSY=0, COUNT=0, READY=1; FIFO read/write pointers=0; state=IDLE; bit-clock counter=0; bit index=0.
  - A partial frame is abandoned and FIFO contents are discarded.
- FIFO:
  - Circular buffer with pointer wrap at FIFO_DEPTH.
  - Push: VALID && READY at an edge writes DATA and increments the write pointer.
  - Pop: internal, driven by the FSM.
  - Push and pop on the same edge: COUNT unchanged, both pointers advance.
  - VALID while READY=0: ignored, no state change; DATA need not be held stable by the block.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TX=1. If COUNT>0 at an edge: pop head into shift register, clear bit counter, go to START; TX=0 from that edge.
  - START: TX=0 for exactly CLK_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: TX = shift_reg[0]; each bit lasts CLK_PER_BIT cycles.
    - At the end of each bit: shift right, increment index.
    - After index 7 completes, go to STOP.
  - STOP: TX=1 for CLK_PER_BIT cycles. On the final cycle edge:
    - if COUNT>0: pop next byte and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Bit-clock counter: width $clog2(CLK_PER_BIT)+1; counts 0..CLK_PER_BIT-1, then resets to 0 at each bit boundary.
- Frame length: exactly 10*CLK_PER_BIT cycles. Back-to-back frames are contiguous.
- Latency: byte pushed at edge E0 into an empty FIFO with FSM in IDLE → TX falls at edge E0+1.
- Capacity: FIFO_DEPTH bytes queued plus 1 byte in the shift register.
- TX is glitch-free: driven from a flop.

Test Plan:
- Timing setup for all scenarios: CLK_HZ=16, BIT_RATE=1 (CLK_PER_BIT=16), FIFO_DEPTH=4; bench decodes TX by sampling mid-bit.
- Single byte: push 0x55 from idle at edge E0 → TX low on cycles E0+1..E0+16, then 1,0,1,0,1,0,1,0 at 16 cycles each, stop high 16 cycles; BUSY high for exactly 160 cycles; COUNT returns 0 at E0+1.
- Back-to-back: push 0xA5 then 0x3C on consecutive edges → two frames, 320 contiguous cycles. Second start bit begins immediately after the first stop bit; decoded bytes are 0xA5, 0x3C; BUSY stays high throughout.
- Full FIFO: push 6 bytes 0x01..0x06 with VALID held high from idle.
  - Bytes 0x01..0x05 accepted on 5 consecutive edges; COUNT reaches 4; READY=0.
  - 0x06 is accepted on the edge after 0x02 is popped (end of frame 1); READY=1 for one cycle.
  - All six bytes decode in order.
- Simultaneous push/pop: COUNT=1 during a STOP final cycle, push on that same edge → COUNT stays 1, next frame starts without gap, bytes in order.
- Reset mid-frame: assert RST during data bit 3 of 0xF0 with 2 bytes queued → TX=1, BUSY=0, COUNT=0, READY=1 immediately. After release, push 0x81 → a clean single frame decoding 0x81, with no residue of the flushed bytes.
